// File: rtl/axis_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// axis_packetizer_pkg_prm
// Shared defaults and types for the AXI-Stream packetizer.
//   DATA_WIDTH : tdata width of both stream ports (>= 32)
//   PKT_LEN    : payload beats per packet (>= 2)
//   TIMEOUT    : idle input cycles before padding starts (>= 2)
//   MAGIC      : 16-bit header marker
//   state_t    : packetizer FSM state encoding
// ---------------------------------------------------------------------------
package axis_packetizer_pkg_prm;

    localparam int          DATA_WIDTH = 32;
    localparam int          PKT_LEN    = 16;
    localparam int          TIMEOUT    = 64;
    localparam logic [15:0] MAGIC      = 16'hA5C3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PAD     = 2'd2
    } state_t;

endpackage

// File: rtl/axis_packetizer_if.sv
// ---------------------------------------------------------------------------
// axis_packetizer_if
// AXI-Stream bundle used on both sides of the packetizer.
//   tdata  : payload word
//   tvalid : source has a word
//   tready : sink accepts the word
//   tlast  : final beat of a packet
// Modports:
//   master : drives tdata/tvalid/tlast, receives tready
//   slave  : receives tdata/tvalid, drives tready. Upstream framing (tlast)
//            is not part of the slave view because the packetizer builds its
//            own packet boundaries.
// ---------------------------------------------------------------------------
interface axis_packetizer_if #(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------
// axis_packetizer
// Wraps an upstream word stream into fixed-length packets: one header beat
// (MAGIC in the top 16 bits, sequence number in the low 16 bits) followed by
// PKT_LEN payload beats. If the upstream goes quiet for TIMEOUT cycles in the
// middle of a packet, the packet is completed with zero-data pad beats.
//
// Ports:
//   aclk       : clock, rising edge
//   aresetn    : synchronous active-low reset
//   s_axis     : upstream stream (slave view)
//   m_axis     : packet stream (master view), fully registered
//   pkt_done   : one-cycle pulse on each tlast output handshake
//   pad_active : high while the FSM is padding a packet
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for upstream data; header loads when oreg is free
// PAYLOAD | forwarding upstream beats, counting idle cycles for timeout
// PAD     | completing a timed-out packet with zero beats
// ---------------------------------------------------------------------------
module axis_packetizer
    import axis_packetizer_pkg_prm::*;
#(
    parameter int          DATA_WIDTH = axis_packetizer_pkg_prm::DATA_WIDTH,
    parameter int          PKT_LEN    = axis_packetizer_pkg_prm::PKT_LEN,
    parameter int          TIMEOUT    = axis_packetizer_pkg_prm::TIMEOUT,
    parameter logic [15:0] MAGIC      = axis_packetizer_pkg_prm::MAGIC
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axis_packetizer_if.slave         s_axis,
    axis_packetizer_if.master        m_axis,
    output logic                     pkt_done,
    output logic                     pad_active
);

    localparam int BCNT_W = $clog2(PKT_LEN + 1);
    localparam int TCNT_W = $clog2(TIMEOUT);

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(PKT_LEN);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    if (DATA_WIDTH < 32) begin : g_bad_width
        $error("axis_packetizer: DATA_WIDTH must be at least 32");
    end
    if (PKT_LEN < 2) begin : g_bad_len
        $error("axis_packetizer: PKT_LEN must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("axis_packetizer: TIMEOUT must be at least 2");
    end

    state_t                state, state_nxt;
    logic [BCNT_W-1:0]     bcnt, bcnt_nxt, bcnt_inc;
    logic [TCNT_W-1:0]     tcnt, tcnt_nxt;
    logic [15:0]           seq, seq_nxt;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_nxt;
    logic                  tvalid_q, tvalid_nxt;
    logic                  tlast_q, tlast_nxt;
    logic [DATA_WIDTH-1:0] header;
    logic                  oreg_free;
    logic                  s_ready;
    logic                  accept;

    assign oreg_free = !tvalid_q || m_axis.tready;
    // Gated by aresetn so upstream never sees ready while reset is held,
    // even though the state register only clears on the next edge.
    assign s_ready   = aresetn && (state == ST_PAYLOAD) && oreg_free;
    assign accept    = s_ready && s_axis.tvalid;
    assign bcnt_inc  = bcnt + 1'b1;

    always_comb begin
        header                          = '0;
        header[DATA_WIDTH-1 -: 16]      = MAGIC;
        header[15:0]                    = seq;
    end

    always_comb begin
        state_nxt  = state;
        bcnt_nxt   = bcnt;
        tcnt_nxt   = tcnt;
        seq_nxt    = seq;
        tdata_nxt  = tdata_q;
        tlast_nxt  = tlast_q;
        // A held beat stays valid until taken; a taken beat empties oreg
        // unless a new one is loaded below.
        tvalid_nxt = tvalid_q && !m_axis.tready;

        case (state)
            ST_IDLE: begin
                if (s_axis.tvalid && oreg_free) begin
                    tdata_nxt  = header;
                    tvalid_nxt = 1'b1;
                    tlast_nxt  = 1'b0;
                    state_nxt  = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
                    tdata_nxt  = s_axis.tdata;
                    tvalid_nxt = 1'b1;
                    tcnt_nxt   = '0;
                    if (bcnt_inc == BCNT_LAST) begin
                        tlast_nxt = 1'b1;
                        bcnt_nxt  = '0;
                        seq_nxt   = seq + 16'd1;
                        state_nxt = ST_IDLE;
                    end else begin
                        tlast_nxt = 1'b0;
                        bcnt_nxt  = bcnt_inc;
                    end
                end else if (s_ready) begin
                    // Only cycles where we could have taken data count as idle;
                    // downstream back-pressure does not advance the timeout.
                    if (tcnt == TCNT_LAST) begin
                        tcnt_nxt  = '0;
                        state_nxt = ST_PAD;
                    end else begin
                        tcnt_nxt  = tcnt + 1'b1;
                    end
                end
            end

            ST_PAD: begin
                if (oreg_free) begin
                    tdata_nxt  = '0;
                    tvalid_nxt = 1'b1;
                    if (bcnt_inc == BCNT_LAST) begin
                        tlast_nxt = 1'b1;
                        bcnt_nxt  = '0;
                        seq_nxt   = seq + 16'd1;
                        state_nxt = ST_IDLE;
                    end else begin
                        tlast_nxt = 1'b0;
                        bcnt_nxt  = bcnt_inc;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            bcnt     <= '0;
            tcnt     <= '0;
            seq      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bcnt     <= bcnt_nxt;
            tcnt     <= tcnt_nxt;
            seq      <= seq_nxt;
            tdata_q  <= tdata_nxt;
            tvalid_q <= tvalid_nxt;
            tlast_q  <= tlast_nxt;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign pkt_done      = aresetn && tvalid_q && m_axis.tready && tlast_q;
    assign pad_active    = aresetn && (state == ST_PAD);

endmodule

// File: tb/tb_axis_packetizer.sv
module tb_axis_packetizer;
    import axis_packetizer_pkg_prm::*;

    localparam int DW   = 32;
    localparam int PLEN = 16;
    localparam int TOUT = 64;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic pkt_done;
    logic pad_active;

    axis_packetizer_if #(.DATA_WIDTH(DW)) s_if ();
    axis_packetizer_if #(.DATA_WIDTH(DW)) m_if ();

    axis_packetizer #(
        .DATA_WIDTH(DW),
        .PKT_LEN   (PLEN),
        .TIMEOUT   (TOUT),
        .MAGIC     (16'hA5C3)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if.slave),
        .m_axis    (m_if.master),
        .pkt_done  (pkt_done),
        .pad_active(pad_active)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream ready: constant 1, or toggling every cycle.
    bit tog = 1'b0;
    always @(posedge aclk) begin
        #1;
        if (tog) m_if.tready = ~m_if.tready;
        else     m_if.tready = 1'b1;
    end

    // Output monitor, sampled mid-cycle.
    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t       obs[$];
    beat_t       exp_q[$];
    int          cyc     = 0;
    int          pkt_cnt = 0;
    int          pad_cyc = 0;
    bit          mon_en  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge aclk) begin
        cyc++;
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, m_if.tvalid}, 32'd1);
                check("hold_data", m_if.tdata, prev_data);
                check("hold_last", {31'b0, m_if.tlast}, {31'b0, prev_last});
            end
            if (m_if.tvalid && m_if.tready)
                obs.push_back('{m_if.tdata, m_if.tlast, cyc});
            if (pkt_done)   pkt_cnt++;
            if (pad_active) pad_cyc++;
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    logic [15:0] exp_seq = 16'h0000;

    task automatic run_case(input int n, input bit tg, input int gap_at, input int gap_len,
                            input int exp_beats, input int exp_pkts, input int exp_pad,
                            input logic [31:0] exp_hdr0, input logic [31:0] start);
        int seg_a, len, done, base, i, gap_left, guard, zeros, nchk;
        bit acc;
        logic [31:0] w;

        // Expected output: timeout splits the stream into two segments,
        // each chunked into packets with the final partial one zero-padded.
        exp_q.delete();
        seg_a = (gap_len >= TOUT) ? gap_at : n;
        base  = 0;
        for (int sg = 0; sg < 2; sg++) begin
            len  = (sg == 0) ? seg_a : n - seg_a;
            done = 0;
            while (done < len) begin
                exp_q.push_back('{{16'hA5C3, exp_seq}, 1'b0, 0});
                for (int b = 0; b < PLEN; b++) begin
                    w = (done + b < len) ? start + 32'(base + done + b) : 32'h0;
                    exp_q.push_back('{w, (b == PLEN - 1), 0});
                end
                done    += PLEN;
                exp_seq += 16'd1;
            end
            base += len;
        end

        obs.delete();
        pkt_cnt = 0;
        pad_cyc = 0;
        tog     = tg;

        i = 0; gap_left = gap_len; guard = 0;
        while (i < n && guard < 2000) begin
            guard++;
            if (i == gap_at && gap_left > 0) begin
                s_if.tvalid = 1'b0;
                gap_left--;
                @(posedge aclk); #1;
            end else begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = start + 32'(i);
                @(negedge aclk);
                acc = s_if.tready;
                @(posedge aclk); #1;
                if (acc) i++;
            end
        end
        if (i < n) check("feed_budget", i, n);
        s_if.tvalid = 1'b0;
        repeat (150) @(posedge aclk);
        #1;
        tog = 1'b0;

        check("beat_count", obs.size(), exp_beats);
        nchk = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        zeros = 0;
        for (int k = 0; k < nchk; k++) begin
            check($sformatf("data[%0d]", k), obs[k].data, exp_q[k].data);
            check($sformatf("last[%0d]", k), {31'b0, obs[k].last}, {31'b0, exp_q[k].last});
        end
        foreach (obs[k]) if (obs[k].data == 32'h0) zeros++;
        check("pkt_done_count", pkt_cnt, exp_pkts);
        check("pad_beats", zeros, exp_pad);
        check("hdr0", (obs.size() > 0) ? obs[0].data : 32'hFFFF_FFFF, exp_hdr0);
        if (!tg) begin
            check("pad_active_cycles", pad_cyc, exp_pad);
            if (obs.size() > 1) check("hdr_latency", obs[1].cyc - obs[0].cyc, 1);
        end else begin
            check("pad_active_seen", {31'b0, pad_cyc > 0}, {31'b0, exp_pad > 0});
        end
    endtask

    typedef struct {
        int          n_in;
        bit          tog;
        int          gap_at;
        int          gap_len;
        int          exp_beats;
        int          exp_pkts;
        int          exp_pad;
        logic [31:0] exp_hdr0;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int i;
        bit acc;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        aresetn     = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
        check("rst_m_tlast", {31'b0, m_if.tlast}, 32'd0);
        check("rst_m_tdata", m_if.tdata, 32'd0);
        check("rst_pkt_done", {31'b0, pkt_done}, 32'd0);
        check("rst_pad_active", {31'b0, pad_active}, 32'd0);
        check("rst_s_tready", {31'b0, s_if.tready}, 32'd0);
        aresetn = 1'b1;
        mon_en  = 1'b1;
        @(posedge aclk); #1;

        //           n   tog gap_at gap  beats pkts pad  hdr0
        vecs[0] = '{32, 1'b0, 0,  0,  34, 2, 0,  32'hA5C30000};
        vecs[1] = '{ 5, 1'b0, 0,  0,  17, 1, 11, 32'hA5C30002};
        vecs[2] = '{20, 1'b1, 0,  0,  34, 2, 12, 32'hA5C30003};
        vecs[3] = '{16, 1'b1, 0,  0,  17, 1, 0,  32'hA5C30005};
        vecs[4] = '{10, 1'b0, 4,  63, 17, 1, 6,  32'hA5C30006};
        vecs[5] = '{10, 1'b0, 4,  64, 34, 2, 22, 32'hA5C30007};
        vecs[6] = '{ 1, 1'b0, 0,  0,  17, 1, 15, 32'hA5C30009};
        vecs[7] = '{ 3, 1'b1, 0,  0,  17, 1, 13, 32'hA5C3000A};

        for (int k = 0; k < 8; k++)
            run_case(vecs[k].n_in, vecs[k].tog, vecs[k].gap_at, vecs[k].gap_len,
                     vecs[k].exp_beats, vecs[k].exp_pkts, vecs[k].exp_pad,
                     vecs[k].exp_hdr0, 32'(k) * 32'h100 + 32'h1);

        // Reset after the 7th accepted payload beat.
        i = 0;
        while (i < 7 && cyc < 20000) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'h5000 + 32'(i);
            @(negedge aclk);
            acc = s_if.tready;
            @(posedge aclk); #1;
            if (acc) i++;
        end
        check("rst_feed", i, 7);
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        check("midrst_s_tready_held", {31'b0, s_if.tready}, 32'd0);
        @(posedge aclk); #1;
        check("midrst_m_tvalid", {31'b0, m_if.tvalid}, 32'd0);
        check("midrst_m_tlast", {31'b0, m_if.tlast}, 32'd0);
        check("midrst_m_tdata", m_if.tdata, 32'd0);
        check("midrst_pkt_done", {31'b0, pkt_done}, 32'd0);
        check("midrst_pad_active", {31'b0, pad_active}, 32'd0);
        check("midrst_s_tready", {31'b0, s_if.tready}, 32'd0);
        aresetn = 1'b1;
        exp_seq = 16'h0000;
        @(posedge aclk); #1;
        run_case(16, 1'b0, 0, 0, 17, 1, 0, 32'hA5C30000, 32'h5101);

        // Sequence wrap: preload the counter near its end instead of
        // streaming 65535 packets.
        force dut.seq = 16'hFFFF;
        @(posedge aclk); #1;
        release dut.seq;
        exp_seq = 16'hFFFF;
        run_case(32, 1'b0, 0, 0, 34, 2, 0, 32'hA5C3FFFF, 32'h6001);
        check("wrap_hdr1", (obs.size() > 17) ? obs[17].data : 32'hFFFF_FFFF, 32'hA5C30000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the tdata width of both ports and SHALL be at least 32.
REQ-002 Parameter PKT_LEN, default 16, is the number of payload beats per packet and SHALL be at least 2.
REQ-003 Parameter TIMEOUT, default 64, is the number of idle input cycles before padding starts and SHALL be at least 2.
REQ-004 Parameter MAGIC, default 16'hA5C3, is the header marker.
REQ-005 aclk  input  1  clock; all logic SHALL be clocked on its rising edge.
REQ-006 aresetn  input  1  reset, synchronous, active-low.
REQ-007 s_axis_tdata  input  DATA_WIDTH  upstream payload, fed by the FIFO master port.
REQ-008 s_axis_tvalid  input  1  upstream valid.
REQ-009 s_axis_tready  output  1  upstream ready.
REQ-010 m_axis_tdata  output  DATA_WIDTH  packet data.
REQ-011 m_axis_tvalid  output  1  packet valid.
REQ-012 m_axis_tready  input  1  downstream ready.
REQ-013 m_axis_tlast  output  1  final beat of a packet.
REQ-014 pkt_done  output  1  one-cycle pulse on each tlast output handshake.
REQ-015 pad_active  output  1  high while the FSM is in PAD.

Function
REQ-016 Each packet SHALL be 1 header beat followed by exactly PKT_LEN payload beats.
REQ-017 The header SHALL be MAGIC in bits [DATA_WIDTH-1:DATA_WIDTH-16] and seq[15:0] in bits [15:0], with all other bits zero.
REQ-018 m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL be registered, forming one output register ("oreg").
REQ-019 oreg is free when !m_axis_tvalid or m_axis_tready; loading a free oreg SHALL sustain one beat per cycle.
REQ-020 Once m_axis_tvalid is high, oreg contents SHALL NOT change until the output handshake completes.
REQ-021 The FSM SHALL have exactly three states: IDLE, PAYLOAD and PAD.
REQ-022 In IDLE, when s_axis_tvalid=1 and oreg is free, the block SHALL load the header into oreg and go to PAYLOAD; s_axis_tready SHALL be 0 in IDLE.
REQ-023 In PAYLOAD, s_axis_tready SHALL equal oreg-free, combinationally.
REQ-024 In PAYLOAD, each accepted beat SHALL load into oreg and increment the beat counter bcnt.
REQ-025 The beat that makes bcnt equal PKT_LEN SHALL carry tlast=1, clear bcnt, increment seq and return the FSM to IDLE.
REQ-026 Timeout counter tcnt SHALL increment in PAYLOAD on cycles with s_axis_tready=1 and s_axis_tvalid=0.
REQ-027 tcnt SHALL clear on any accepted beat and on state exit; cycles stalled by downstream (oreg not free) SHALL NOT count.
REQ-028 When tcnt reaches TIMEOUT-1 and a further idle cycle occurs, the FSM SHALL go to PAD.
REQ-029 In PAD, s_axis_tready SHALL be 0, and a zero-data beat SHALL load into oreg whenever oreg is free until bcnt reaches PKT_LEN.
REQ-030 The final pad beat SHALL carry tlast=1, increment seq and return the FSM to IDLE.
REQ-031 If the timeout occurs when the last accepted payload beat completed the packet, the FSM SHALL already be in IDLE and no pad beats SHALL be produced.
REQ-032 seq SHALL be 16 bits and wrap from 16'hFFFF to 16'h0000.
REQ-033 bcnt SHALL be $clog2(PKT_LEN+1) bits and tcnt SHALL be $clog2(TIMEOUT) bits.
REQ-034 Header-to-first-payload latency SHALL be 1 cycle when m_axis_tready=1.

Reset
REQ-035 Under reset, m_axis_tvalid, m_axis_tlast, m_axis_tdata, pkt_done and pad_active SHALL be 0.
REQ-036 Under reset, state SHALL be IDLE and bcnt, tcnt and seq SHALL be 0.
REQ-037 s_axis_tready SHALL be 0 during reset.
REQ-038 Reset asserted mid-packet SHALL discard the partial packet, and the next packet SHALL carry seq 0.

Structure
REQ-039 Package axis_packetizer_pkg_prm SHALL hold DATA_WIDTH, PKT_LEN, TIMEOUT, MAGIC and the state enum type.
REQ-040 The block SHALL be a single module with no sub-modules.

Verification
REQ-041 Stream 32 beats 1..32 with m_axis_tready=1 -> 2 packets: hdr A5C30000, 1..16 with tlast on 16; hdr A5C30001, 17..32; 2 pkt_done pulses.
REQ-042 Send 5 beats then hold tvalid=0 for 64 cycles -> hdr, 5 data beats, 11 zero beats with tlast on the last, pad_active high during padding.
REQ-043 Stream continuous input with m_axis_tready toggling 1/0 every cycle -> no lost or duplicated beats, oreg stable while stalled, no timeout.
REQ-044 Drive 65537 packets -> header seq wraps FFFF to 0000.
REQ-045 Assert aresetn=0 for 1 cycle after the 7th payload beat -> all outputs 0, then the next packet header is A5C30000.
